// File: rtl/abus_rr.sv
// ---------------------------------------------------------------------------
// abus_rr -- round-robin bus arbiter with one-cycle turnaround between tenures
//
// A granted master keeps the bus for as long as it holds its request bit; no
// other master can pre-empt it. When the owner drops its request the grant is
// cleared, the owner becomes the new round-robin pointer, and the bus spends
// exactly one cycle idle (RELEASE) before the next winner is picked. The
// search for a winner starts at the master just above the pointer and wraps.
//
// Optional feature (compile-time macro ABUS_RR_TIMEOUT_EN):
//   a hold counter limits each tenure to MAX_HOLD cycles. On expiry the grant
//   is revoked and timeout_err pulses for one cycle. Without the macro tenures
//   are unlimited and timeout_err is constant 0.
//
// Parameters:
//   N           number of masters (>= 2)
//   MAX_HOLD    maximum grant cycles per tenure (timeout build only)
//
// Ports:
//   clk          in   1              clock, rising edge
//   rst_n        in   1              asynchronous active-low reset
//   req          in   N              per-master request / keep-bus
//   grant        out  N              registered grant, one-hot or zero
//   grant_idx    out  $clog2(N)      index of granted master, 0 when idle
//   busy         out  1              high while any grant bit is high
//   timeout_err  out  1              one-cycle pulse on forced revocation
// ---------------------------------------------------------------------------
module abus_rr #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int IW = $clog2(N);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]    r_state;
  logic [IW-1:0] r_ptr;
  logic [N-1:0]  r_grant;
  logic [IW-1:0] r_grantIdx;
  logic          r_busy;

  logic          w_found;
  logic [IW-1:0] w_winner;
  logic [IW-1:0] w_scanIdx;
  logic [N-1:0]  w_winnerOh;
  logic          w_keep;
  logic          w_expire;

  // Round-robin search: walk from the farthest candidate back towards ptr+1
  // so the last hit written is the nearest one above the pointer.
  always_comb begin
    w_found   = 1'b0;
    w_winner  = '0;
    w_scanIdx = '0;
    for (int k = N; k >= 1; k--) begin
      w_scanIdx = IW'((int'(r_ptr) + k) % N);
      if (req[w_scanIdx]) begin
        w_found  = 1'b1;
        w_winner = w_scanIdx;
      end
    end
  end

  assign w_winnerOh = N'(1) << w_winner;
  assign w_keep     = req[r_grantIdx];

`ifdef ABUS_RR_TIMEOUT_EN
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [HW-1:0] r_hold;
  logic          r_timeoutErr;

  // Expiry only counts while the owner still wants the bus, so a voluntary
  // release on the last allowed cycle wins and raises no error.
  assign w_expire = (r_state == S_BUSY) && w_keep && (r_hold == HW'(MAX_HOLD - 1));

  // Tenure length counter: runs during BUSY, sits at zero otherwise so every
  // new tenure starts counting from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold       <= '0;
      r_timeoutErr <= 1'b0;
    end else begin
      r_timeoutErr <= w_expire;
      if ((r_state == S_BUSY) && w_keep && !w_expire) begin
        r_hold <= r_hold + 1'b1;
      end else begin
        r_hold <= '0;
      end
    end
  end

  assign timeout_err = r_timeoutErr;
`else
  assign w_expire = 1'b0;
  // MAX_HOLD has no effect in this build; folding it into the constant keeps
  // the parameter referenced without changing the tied-off value.
  assign timeout_err = 1'b0 & (MAX_HOLD != 0);
`endif

  // Main arbiter FSM. Grant, index and busy are all registered together so
  // they stay mutually consistent every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= IW'(N - 1);
      r_grant    <= '0;
      r_grantIdx <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_RELEASE: begin
          if (w_found) begin
            r_state    <= S_BUSY;
            r_grant    <= w_winnerOh;
            r_grantIdx <= w_winner;
            r_busy     <= 1'b1;
          end else begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_grantIdx <= '0;
            r_busy     <= 1'b0;
          end
        end
        S_BUSY: begin
          if (!w_keep || w_expire) begin
            r_state    <= S_RELEASE;
            r_ptr      <= r_grantIdx;
            r_grant    <= '0;
            r_grantIdx <= '0;
            r_busy     <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_grant    <= '0;
          r_grantIdx <= '0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign grant     = r_grant;
  assign grant_idx = r_grantIdx;
  assign busy      = r_busy;

endmodule

// File: tb/tb_abus_rr.sv
// ---------------------------------------------------------------------------
// tb_abus_rr -- directed scoreboard bench for abus_rr (N=8, MAX_HOLD=16)
//
// Each stimulus cycle pushes the hand-computed response expected one edge
// later; a monitor pops and compares a little after every rising edge. A
// second monitor checks the one-hot-or-zero property on every falling edge.
// Define ABUS_RR_TIMEOUT_EN for both bench and RTL to exercise the timeout.
// ---------------------------------------------------------------------------
module tb_abus_rr;

  typedef struct packed {
    logic [7:0] grant;
    logic [2:0] idx;
    logic       busy;
    logic       terr;
  } expT;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       busy;
  logic       timeout_err;

  int  checks   = 0;
  int  failures = 0;
  expT expQ[$];

  abus_rr #(
    .N        (8),
    .MAX_HOLD (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] idxOf(input logic [7:0] oh);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Drive one request vector and queue the response expected after the edge.
  task automatic applyStimulus(input logic [7:0] reqVal, input logic [7:0] expGrant,
                               input logic expTerr);
    expT e;
    @(negedge clk);
    req    = reqVal;
    e.grant = expGrant;
    e.idx   = idxOf(expGrant);
    e.busy  = |expGrant;
    e.terr  = expTerr;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input expT e);
    checks++;
    if (grant !== e.grant || grant_idx !== e.idx || busy !== e.busy || timeout_err !== e.terr) begin
      failures++;
      $display("[TB] FAIL cycle t=%0t got grant=%h idx=%0d busy=%b terr=%b, expected grant=%h idx=%0d busy=%b terr=%b",
               $time, grant, grant_idx, busy, timeout_err, e.grant, e.idx, e.busy, e.terr);
    end
  endtask

  task automatic checkReset(input string name);
    checks++;
    if (grant !== 8'h00 || grant_idx !== 3'd0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s got grant=%h idx=%0d busy=%b terr=%b, expected all zero",
               name, grant, grant_idx, busy, timeout_err);
    end
  endtask

  // Asynchronous reset pulse in the middle of a cycle; outputs must clear
  // before any clock edge arrives.
  task automatic doReset(input string name);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkReset(name);
    req = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: compares a registered response after every edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  // Grant must never have more than one bit set.
  always @(negedge clk) begin
    checks++;
    if (!$onehot0(grant)) begin
      failures++;
      $display("[TB] FAIL onehot got grant=%h, expected at most one bit set", grant);
    end
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog got no completion, expected finish before t=200000");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [7:0] g;
    req   = 8'h00;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 checkReset("resetAsync");
    @(posedge clk);
    #1 checkReset("resetHeld");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] arbitration from reset and full rotation");
    applyStimulus(8'hFF, 8'h01, 1'b0);
    applyStimulus(8'hFF, 8'h01, 1'b0);
    applyStimulus(8'hFF, 8'h01, 1'b0);
    applyStimulus(8'hFE, 8'h00, 1'b0);
    for (int i = 1; i < 8; i++) begin
      g = 8'(1 << i);
      applyStimulus(8'hFF, g, 1'b0);
      applyStimulus(8'hFF, g, 1'b0);
      applyStimulus(8'hFF & ~g, 8'h00, 1'b0);
    end
    applyStimulus(8'hFF, 8'h01, 1'b0);
    applyStimulus(8'hFF, 8'h01, 1'b0);
    applyStimulus(8'hFE, 8'h00, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);

    $display("[TB] lone master re-request after release");
    applyStimulus(8'h10, 8'h10, 1'b0);
    applyStimulus(8'h10, 8'h10, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);
    applyStimulus(8'h10, 8'h10, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);

    $display("[TB] no preemption, transient request forgotten, wrap");
    applyStimulus(8'h21, 8'h20, 1'b0);
    applyStimulus(8'h23, 8'h20, 1'b0);
    applyStimulus(8'h21, 8'h20, 1'b0);
    applyStimulus(8'h01, 8'h00, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);
    applyStimulus(8'h81, 8'h80, 1'b0);
    applyStimulus(8'h01, 8'h00, 1'b0);
    applyStimulus(8'h01, 8'h01, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);

    $display("[TB] reset mid-tenure");
    applyStimulus(8'h04, 8'h04, 1'b0);
    applyStimulus(8'h04, 8'h04, 1'b0);
    doReset("resetMidTenure");
    applyStimulus(8'hFF, 8'h01, 1'b0);
    applyStimulus(8'hFF, 8'h01, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);

    doReset("resetBeforeHold");
`ifdef ABUS_RR_TIMEOUT_EN
    $display("[TB] tenure timeout and voluntary release at expiry");
    for (int i = 0; i < 16; i++) applyStimulus(8'h03, 8'h01, 1'b0);
    applyStimulus(8'h03, 8'h00, 1'b1);
    applyStimulus(8'h03, 8'h02, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(8'h01, 8'h01, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);
`else
    $display("[TB] unlimited tenure");
    for (int i = 0; i < 100; i++) applyStimulus(8'h03, 8'h01, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);
`endif

    repeat (3) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain got %0d pending responses, expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/abus_rr.md
ABUS_RR -- requirements
Module: abus_rr

Interface
- REQ-001: Parameter N, default 8, number of requesting masters (N >= 2).
- REQ-002: Parameter MAX_HOLD, default 16, maximum consecutive grant cycles per tenure (timeout build only).
- REQ-003: clk  input  1  clock; all state updates on rising edge.
- REQ-004: rst_n  input  1  asynchronous, active-low reset.
- REQ-005: req  input  N  per-master request; bit i high = master i wants or keeps the bus.
- REQ-006: grant  output  N  registered grant; one-hot or all-zero.
- REQ-007: grant_idx  output  $clog2(N)  index of the granted master; 0 when grant is zero.
- REQ-008: busy  output  1  high while any grant bit is high.
- REQ-009: timeout_err  output  1  one-cycle pulse on forced revocation; tied 0 when the feature is compiled out.

Function
- REQ-010: The FSM SHALL have exactly three states: IDLE, BUSY, RELEASE.
- REQ-011: IDLE or RELEASE with req != 0 -> BUSY; the winner is granted on the same edge (1-cycle latency from sampled req to grant).
- REQ-012: Winner: first set bit of req searched upward from ptr+1, wrapping modulo N; ptr = last granted index.
- REQ-013: IDLE or RELEASE with req == 0 -> IDLE; grant stays 0.
- REQ-014: BUSY with req[grant_idx] = 1 -> grant held unchanged; other req bits are ignored (no preemption).
- REQ-015: BUSY with req[grant_idx] = 0 -> grant cleared on that edge, ptr <= grant_idx, next state RELEASE.
- REQ-016: RELEASE holds grant = 0 for exactly one cycle (bus turnaround), then arbitrates per REQ-011/REQ-013.
- REQ-017: Minimum gap between consecutive tenures: one all-zero grant cycle.
- REQ-018: grant SHALL never have more than one bit set, in any cycle, any build.
- REQ-019: A master requesting continuously while others rotate SHALL be granted within N tenures (no starvation).
- REQ-020: busy = |grant, registered alongside grant; grant_idx consistent with grant every cycle.
- REQ-021: A request raised and dropped while another master holds the bus is not remembered.

Reset
- REQ-022: rst_n low SHALL immediately force grant = 0, grant_idx = 0, busy = 0, timeout_err = 0, state = IDLE, ptr = N-1, hold counter = 0.
- REQ-023: Reset asserted mid-tenure SHALL drop grant without passing through RELEASE; first post-reset arbitration favours master 0.
- REQ-024: Deassertion of rst_n is synchronised by the caller; the block is not required to tolerate a deassertion coincident with a clock edge.

Configuration
- REQ-025: Macro ABUS_RR_TIMEOUT_EN defined: a hold counter increments each BUSY cycle and clears on entering BUSY.
- REQ-026: With ABUS_RR_TIMEOUT_EN, a BUSY cycle with counter = MAX_HOLD-1 and req[grant_idx] still 1 SHALL clear grant, pulse timeout_err for one cycle, set ptr <= grant_idx and go to RELEASE.
- REQ-027: With ABUS_RR_TIMEOUT_EN, a voluntary release on the same cycle as expiry takes precedence; no timeout_err.
- REQ-028: Without ABUS_RR_TIMEOUT_EN: no hold counter, tenure unlimited, timeout_err constant 0, MAX_HOLD unused.

Verification (N=8, MAX_HOLD=16)
- REQ-029: After reset, req=8'hFF held -> grant=8'h01 one edge later, held while req[0]=1, busy=1, grant_idx=0.
- REQ-030: All masters request; each drops req for one cycle after 2 granted cycles, then re-requests -> grant sequence 01,02,04,...,80,01 with exactly one zero cycle between tenures.
- REQ-031: Master 4 served, released; req=8'h10 alone -> grant 0 for one cycle, then grant=8'h10 again.
- REQ-032: rst_n pulsed low while grant=8'h04 -> grant=0 asynchronously; req=8'hFF afterwards -> grant=8'h01.
- REQ-033: ABUS_RR_TIMEOUT_EN defined, req=8'h03 held -> grant=01 for 16 cycles, timeout_err one-cycle pulse, one zero cycle, grant=02.
- REQ-034: ABUS_RR_TIMEOUT_EN undefined, same stimulus for 100 cycles -> grant=01 throughout, timeout_err=0; one-hot-or-zero checked every negedge in all scenarios.
